// File: rtl/sequenciador_acesso_memoria.sv
// Memory-stage access sequencer: splits 32-bit word loads/stores into two
// 16-bit halfword accesses towards MemDados and assembles/sign-extends load results.
module sequenciador_acesso_memoria #(
  parameter int LARGURA_END = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   req_valido,
  input  logic                   req_escrita,
  input  logic                   req_palavra,
  input  logic [LARGURA_END-1:0] req_endereco,
  input  logic [31:0]            req_dado,
  output logic                   req_pronto,
  output logic                   ocupado,
  output logic                   resp_valido,
  output logic [31:0]            resp_dado,
  output logic                   erro_alinhamento,
  output logic [LARGURA_END-1:0] mem_endereco,
  output logic [31:0]            mem_valor,
  output logic                   mem_escrita,
  output logic                   mem_leitura,
  input  logic [31:0]            mem_dado
);

  typedef enum logic [2:0] {OCIOSO, BAIXA, ALTA, FIM, ERRO} estado_t;

  estado_t                estado_q, estado_d;
  logic                   escrita_q, escrita_d;
  logic                   palavra_q, palavra_d;
  logic [LARGURA_END-1:0] end_q, end_d;
  logic [31:0]            dado_q, dado_d;
  logic [15:0]            parte_baixa_q, parte_baixa_d;
  logic [15:0]            parte_alta_q, parte_alta_d;
  logic                   desalinhado;
  logic                   unused_mem_dado_alto;

  // The memory sign-extends halfwords itself; only the low 16 bits carry data.
  assign unused_mem_dado_alto = ^mem_dado[31:16];

  assign desalinhado = req_palavra ? (req_endereco[1:0] != 2'b00) : req_endereco[0];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q      <= OCIOSO;
      escrita_q     <= 1'b0;
      palavra_q     <= 1'b0;
      end_q         <= '0;
      dado_q        <= '0;
      parte_baixa_q <= '0;
      parte_alta_q  <= '0;
    end else begin
      estado_q      <= estado_d;
      escrita_q     <= escrita_d;
      palavra_q     <= palavra_d;
      end_q         <= end_d;
      dado_q        <= dado_d;
      parte_baixa_q <= parte_baixa_d;
      parte_alta_q  <= parte_alta_d;
    end
  end

  always_comb begin
    estado_d      = estado_q;
    escrita_d     = escrita_q;
    palavra_d     = palavra_q;
    end_d         = end_q;
    dado_d        = dado_q;
    parte_baixa_d = parte_baixa_q;
    parte_alta_d  = parte_alta_q;
    case (estado_q)
      OCIOSO: begin
        if (req_valido) begin
          escrita_d = req_escrita;
          palavra_d = req_palavra;
          end_d     = req_endereco;
          dado_d    = req_dado;
          estado_d  = desalinhado ? ERRO : BAIXA;
        end
      end
      BAIXA: begin
        if (!escrita_q) parte_baixa_d = mem_dado[15:0];
        estado_d = palavra_q ? ALTA : FIM;
      end
      ALTA: begin
        if (!escrita_q) parte_alta_d = mem_dado[15:0];
        estado_d = FIM;
      end
      FIM:     estado_d = OCIOSO;
      ERRO:    estado_d = OCIOSO;
      default: estado_d = OCIOSO;
    endcase
  end

  // Outputs decode registered state only, so mem_escrita stays glitch-free
  // across the whole cycle for the negedge-writing memory.
  always_comb begin
    req_pronto       = 1'b0;
    ocupado          = 1'b1;
    resp_valido      = 1'b0;
    resp_dado        = '0;
    erro_alinhamento = 1'b0;
    mem_endereco     = '0;
    mem_valor        = '0;
    mem_escrita      = 1'b0;
    mem_leitura      = 1'b0;
    case (estado_q)
      OCIOSO: begin
        req_pronto = 1'b1;
        ocupado    = 1'b0;
      end
      BAIXA: begin
        mem_endereco = end_q;
        mem_escrita  = escrita_q;
        mem_leitura  = !escrita_q;
        if (escrita_q) mem_valor = {16'h0, dado_q[15:0]};
      end
      ALTA: begin
        mem_endereco = end_q + LARGURA_END'(2);
        mem_escrita  = escrita_q;
        mem_leitura  = !escrita_q;
        if (escrita_q) mem_valor = {16'h0, dado_q[31:16]};
      end
      FIM: begin
        resp_valido = 1'b1;
        if (!escrita_q) begin
          if (palavra_q) resp_dado = {parte_alta_q, parte_baixa_q};
          else           resp_dado = {{16{parte_baixa_q[15]}}, parte_baixa_q};
        end
      end
      ERRO: begin
        resp_valido      = 1'b1;
        erro_alinhamento = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
